vec_mem_seq: RTL and testbench

Vector load/store sequencer for the CVP14 core. It executes VLD and VST by moving a 256-bit vector (16 × 16-bit elements) between the vector register file and the 16-bit external memory bus, one element per cycle. It owns the Addr, RD, WR and dataOut pins while busy, and drives the vector register file write port on load completion. Instruction decode starts it; a bus grant input lets fetch share the bus.

---
 rtl/vec_mem_seq_pkg.sv | 38 +++
 rtl/vec_mem_seq_if.sv | 34 +++
 rtl/vec_mem_seq.sv | 123 ++++++++++++
 tb/tb_vec_mem_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_seq_pkg.sv
// Shared CVP14 constants used by the vector load/store sequencer.
// Holds the opcode encodings, vector geometry and the sequencer state encoding.
package vec_mem_seq_pkg;

    localparam int ELEMS = 16;
    localparam int EW    = 16;
    localparam int VW    = ELEMS * EW;
    localparam int AW    = 16;
    localparam int IW    = 3;
    localparam int KW    = 4;

    typedef enum logic [3:0] {
        VADD = 4'h0,
        VDOT = 4'h1,
        SMUL = 4'h2,
        SST  = 4'h3,
        VLD  = 4'h4,
        VST  = 4'h5,
        SLL  = 4'h6,
        SLH  = 4'h7,
        J    = 4'h8,
        NOP  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_DRAIN,
        S_WB,
        S_WR_ISSUE,
        S_FIN
    } seq_state_e;

    function automatic logic [EW-1:0] elem_of(input logic [VW-1:0] v, input logic [KW-1:0] k);
        return v[k*EW +: EW];
    endfunction

endpackage

// File: rtl/vec_mem_seq_if.sv
// Decode request, memory bus and VRF write-port signals of the vector load/store sequencer.
// The master modport is the sequencer; the slave modport is decode, memory and VRF together.
interface vec_mem_seq_if;
    import vec_mem_seq_pkg::*;

    logic          start;
    logic          is_store;
    logic [AW-1:0] base_addr;
    logic [IW-1:0] vreg_idx;
    logic [VW-1:0] vst_data;
    logic          mem_gnt;
    logic [EW-1:0] DataIn;

    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [EW-1:0] dataOut;
    logic          busy;
    logic          done;
    logic          vrf_wr_en;
    logic [IW-1:0] vrf_wr_dst;
    logic [VW-1:0] vrf_wr_data;

    modport master (
        input  start, is_store, base_addr, vreg_idx, vst_data, mem_gnt, DataIn,
        output Addr, RD, WR, dataOut, busy, done, vrf_wr_en, vrf_wr_dst, vrf_wr_data
    );

    modport slave (
        output start, is_store, base_addr, vreg_idx, vst_data, mem_gnt, DataIn,
        input  Addr, RD, WR, dataOut, busy, done, vrf_wr_en, vrf_wr_dst, vrf_wr_data
    );

endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves 16 x 16-bit elements between the VRF and the
// 16-bit memory bus, one element per granted cycle.
//
// state      | meaning
// S_IDLE     | waiting for start; latches operands on start
// S_RD_ISSUE | VLD: issue one read per granted cycle, elements 0..15
// S_RD_DRAIN | VLD: capture the last read's data
// S_WB       | VLD: write assembled vector to the VRF, pulse done
// S_WR_ISSUE | VST: issue one write per granted cycle, elements 0..15
// S_FIN      | VST: pulse done
module vec_mem_seq
    import vec_mem_seq_pkg::*;
(
    input  logic          Clk1,
    input  logic          Reset,
    vec_mem_seq_if.master bus
);

    seq_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] base_q, base_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [VW-1:0] vec_q, vec_d;
    logic          pend_q, pend_d;
    logic [KW-1:0] pidx_q, pidx_d;

    logic          rd, wr, done, wr_en;
    logic [AW-1:0] addr;
    logic [EW-1:0] dout;

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        pend_d  = 1'b0;
        pidx_d  = k_q;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        dout    = '0;
        done    = 1'b0;
        wr_en   = 1'b0;

        // Read data belongs to the element issued last cycle, whatever the grant is now.
        if (pend_q) begin
            vec_d[pidx_q*EW +: EW] = bus.DataIn;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    idx_d   = bus.vreg_idx;
                    k_d     = '0;
                    vec_d   = bus.is_store ? bus.vst_data : '0;
                    state_d = bus.is_store ? S_WR_ISSUE : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                if (bus.mem_gnt) begin
                    rd     = 1'b1;
                    addr   = base_q + AW'(k_q);
                    pend_d = 1'b1;
                    k_d    = k_q + KW'(1);
                    if (k_q == KW'(ELEMS - 1)) state_d = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: state_d = S_WB;
            S_WB: begin
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_WR_ISSUE: begin
                if (bus.mem_gnt) begin
                    wr   = 1'b1;
                    addr = base_q + AW'(k_q);
                    dout = elem_of(vec_q, k_q);
                    k_d  = k_q + KW'(1);
                    if (k_q == KW'(ELEMS - 1)) state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.Addr        = addr;
    assign bus.RD          = rd;
    assign bus.WR          = wr;
    assign bus.dataOut     = dout;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done;
    assign bus.vrf_wr_en   = wr_en;
    assign bus.vrf_wr_dst  = wr_en ? idx_q : '0;
    assign bus.vrf_wr_data = wr_en ? vec_q : '0;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: memory model, address/data scoreboard, cycle-exact
// busy/done/VRF-write expectations and a mid-transfer reset.
module tb_vec_mem_seq;
    import vec_mem_seq_pkg::*;

    logic Clk1  = 1'b0;
    logic Reset = 1'b1;

    vec_mem_seq_if bus();

    vec_mem_seq dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk1 = ~Clk1;

    logic [15:0]   mem [0:65535];
    int            n_pass  = 0;
    int            n_total = 0;
    logic [15:0]   exp_addr_q[$];
    logic [15:0]   exp_wdata_q[$];
    logic [VW-1:0] exp_vec_q[$];
    logic          rd_pend;
    logic [15:0]   rd_addr;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [319:0] out_bundle();
        return {24'b0, bus.Addr, bus.RD, bus.WR, bus.dataOut, bus.busy, bus.done,
                bus.vrf_wr_en, bus.vrf_wr_dst, bus.vrf_wr_data};
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.is_store  = 1'b0;
        bus.base_addr = '0;
        bus.vreg_idx  = '0;
        bus.vst_data  = '0;
        bus.mem_gnt   = 1'b1;
        bus.DataIn    = 16'hDEAD;
    endtask

    task automatic run_op(input logic st, input logic [15:0] base, input logic [2:0] idx,
                          input logic [VW-1:0] vdata, input logic [63:0] stall_mask,
                          input int exp_done, input int late_start, input string name);
        logic [VW-1:0] ev = '0;
        logic [VW-1:0] got = '0;
        logic [15:0]   a;
        logic [15:0]   d;
        bit            finished = 1'b0;
        rd_pend = 1'b0;
        for (int i = 0; i < ELEMS; i++) begin
            exp_addr_q.push_back(base + 16'(i));
            if (st) exp_wdata_q.push_back(vdata[i*EW +: EW]);
            else    ev[i*EW +: EW] = mem[base + 16'(i)];
        end
        if (!st) exp_vec_q.push_back(ev);

        for (int c = 0; c < 60 && !finished; c++) begin
            @(negedge Clk1);
            bus.DataIn    = rd_pend ? mem[rd_addr] : 16'hDEAD;
            bus.mem_gnt   = !stall_mask[c];
            bus.start     = (c == 0) || (c == late_start);
            bus.is_store  = (c == 0) ? st : !st;
            bus.base_addr = (c == 0) ? base : 16'h7000;
            bus.vreg_idx  = (c == 0) ? idx : ~idx;
            bus.vst_data  = (c == 0) ? vdata : ~vdata;
            #1;
            check({name, " busy"}, 320'(bus.busy), 320'(c >= 1 && c <= exp_done));
            check({name, " strobe_excl"}, 320'(bus.RD & bus.WR), 320'(0));
            if (stall_mask[c]) check({name, " stall_quiet"}, 320'({bus.RD, bus.WR}), 320'(0));
            rd_pend = bus.RD;
            rd_addr = bus.Addr;
            if (bus.RD || bus.WR) begin
                check({name, " strobe_kind"}, 320'({bus.RD, bus.WR}), 320'({!st, st}));
                if (exp_addr_q.size() == 0) begin
                    check({name, " extra_strobe"}, 320'({bus.RD, bus.WR}), 320'(0));
                end else begin
                    a = exp_addr_q.pop_front();
                    check({name, " addr"}, 320'(bus.Addr), 320'(a));
                    if (bus.WR && exp_wdata_q.size() != 0) begin
                        d = exp_wdata_q.pop_front();
                        check({name, " dataOut"}, 320'(bus.dataOut), 320'(d));
                    end
                    if (bus.WR) mem[bus.Addr] = bus.dataOut;
                end
            end else begin
                check({name, " idle_bus"}, 320'({bus.Addr, bus.dataOut}), 320'(0));
            end
            check({name, " done"}, 320'(bus.done), 320'(c == exp_done));
            check({name, " vrf_wr_en"}, 320'(bus.vrf_wr_en), 320'(c == exp_done && !st));
            if (bus.vrf_wr_en) begin
                check({name, " vrf_wr_dst"}, 320'(bus.vrf_wr_dst), 320'(idx));
                if (exp_vec_q.size() != 0)
                    check({name, " vrf_wr_data"}, 320'(bus.vrf_wr_data), 320'(exp_vec_q.pop_front()));
                else
                    check({name, " extra_vrf_wr"}, 320'(bus.vrf_wr_en), 320'(0));
            end
            if (c == exp_done + 1) finished = 1'b1;
        end
        bus.start = 1'b0;
        check({name, " all_issued"}, 320'(exp_addr_q.size()), 320'(0));
        check({name, " completed"}, 320'(finished), 320'(1));
        if (st) begin
            for (int i = 0; i < ELEMS; i++) got[i*EW +: EW] = mem[base + 16'(i)];
            check({name, " memory"}, 320'(got), 320'(vdata));
        end
        exp_addr_q.delete();
        exp_wdata_q.delete();
        exp_vec_q.delete();
    endtask

    task automatic reset_mid_vld();
        bus.DataIn = 16'hDEAD;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk1);
            bus.start     = (c == 0);
            bus.is_store  = 1'b0;
            bus.base_addr = 16'h0100;
            bus.vreg_idx  = 3'd5;
            bus.mem_gnt   = 1'b1;
        end
        @(negedge Clk1);
        bus.start = 1'b0;
        Reset     = 1'b0;
        #1;
        check("rst_mid outputs", out_bundle(), 320'(0));
        repeat (2) begin
            @(negedge Clk1);
            #1;
            check("rst_mid held", out_bundle(), 320'(0));
        end
        Reset = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge Clk1);
            #1;
            check("rst_mid quiet", 320'({bus.busy, bus.done, bus.vrf_wr_en, bus.RD}), 320'(0));
        end
    endtask

    logic [VW-1:0] v_a, v_b, v_c;

    initial begin
        idle_inputs();
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C3C;
        for (int i = 0; i < ELEMS; i++) begin
            mem[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
            v_a[i*EW +: EW] = 16'h5A00 + 16'(i);
            v_b[i*EW +: EW] = 16'hC300 + 16'(i);
            v_c[i*EW +: EW] = 16'h1E10 + 16'(i * 3);
        end

        #2 Reset = 1'b0;
        #1;
        check("reset outputs", out_bundle(), 320'(0));
        @(negedge Clk1);
        #1;
        check("reset held", out_bundle(), 320'(0));
        Reset = 1'b1;

        run_op(1'b0, 16'h0100, 3'd3, '0,  64'h0, 18, -1, "vld");
        run_op(1'b1, 16'h0200, 3'd0, v_a, 64'h0, 17, -1, "vst");
        run_op(1'b0, 16'h0100, 3'd6, '0,  (64'd1 << 3) | (64'd1 << 10), 20, -1, "vld_stall");
        run_op(1'b1, 16'hFFF8, 3'd0, v_b, 64'h0, 17, -1, "vst_wrap");
        run_op(1'b0, 16'h0200, 3'd1, '0,  64'h0, 18, 5, "vld_busy_start");
        run_op(1'b1, 16'h0400, 3'd2, v_c, (64'd1 << 1) | (64'd1 << 16), 19, 9, "vst_stall_busy");
        reset_mid_vld();
        run_op(1'b0, 16'h0100, 3'd7, '0,  64'h0, 18, -1, "vld_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
